// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment display path.
// Holds the digit-multiplexer FSM state encoding and segment/cathode levels.
// Pure declarations; no logic lives here.
package seven_segment_pkg;

  // Multiplexer phases in cyclic order: blank, low digit, blank, high digit.
  typedef enum logic [1:0] {
    BLANK_TO_LO = 2'd0,
    SHOW_LO     = 2'd1,
    BLANK_TO_HI = 2'd2,
    SHOW_HI     = 2'd3
  } seg_state_e;

  // Active-low segment bus with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Cathode select levels for the dual-digit PMOD.
  localparam logic DIGIT_LO = 1'b1;
  localparam logic DIGIT_HI = 1'b0;

endpackage

// File: rtl/sev_seg_mux_if.sv
// Display bus between the value source and the seven-segment multiplexer.
// Carries the value/enable inputs and the registered PMOD drive outputs.
// No handshake: the value is sampled once per frame by the multiplexer.
interface sev_seg_mux_if;

  logic [7:0] i_value;
  logic       i_enable;
  logic [6:0] o_segments;
  logic       o_cathode;
  logic       o_frame;

  // Value source side.
  modport master (
    output i_value,
    output i_enable,
    input  o_segments,
    input  o_cathode,
    input  o_frame
  );

  // Multiplexer side.
  modport slave (
    input  i_value,
    input  i_enable,
    output o_segments,
    output o_cathode,
    output o_frame
  );

endinterface

// File: rtl/bcd.sv
// Hex nibble to seven-segment decoder, active-high, bit 0 = a ... bit 6 = g.
// Purely combinational, zero latency.
// No flow control.
module bcd (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  // Glyph lookup for 0-9 and A-F (b and d in lower case).
  always_comb begin
    o_segments = 7'h00;
    case (i_nibble)
      4'h0: o_segments = 7'h3F;
      4'h1: o_segments = 7'h06;
      4'h2: o_segments = 7'h5B;
      4'h3: o_segments = 7'h4F;
      4'h4: o_segments = 7'h66;
      4'h5: o_segments = 7'h6D;
      4'h6: o_segments = 7'h7D;
      4'h7: o_segments = 7'h07;
      4'h8: o_segments = 7'h7F;
      4'h9: o_segments = 7'h6F;
      4'hA: o_segments = 7'h77;
      4'hB: o_segments = 7'h7C;
      4'hC: o_segments = 7'h39;
      4'hD: o_segments = 7'h5E;
      4'hE: o_segments = 7'h79;
      default: o_segments = 7'h71;
    endcase
  end

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexes the two hex digits of an 8-bit value onto the dual-digit PMOD.
// Outputs registered: each state's drive appears in the first cycle of that state.
// No backpressure; the value is latched on entry to SHOW_LO and held for the frame.
module sev_seg_mux
  import seven_segment_pkg::*;
#(
  parameter int unsigned REFRESH_DIV           = 1200,
  parameter int unsigned BLANK_CYCLES          = 16,
  parameter bit          SUPPRESS_LEADING_ZERO = 1'b0
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  sev_seg_mux_if.slave  bus
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  // With no blanking the blank state is only ever seen once after reset and is
  // left on the very next edge, so its terminal count is irrelevant.
  localparam logic [CW-1:0] BLANK_LAST = HAS_BLANK ? CW'(BLANK_CYCLES - 1) : '0;

  seg_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    val_q, val_d;
  logic [6:0]    seg_q, seg_d;
  logic          cath_q, cath_d;
  logic          frame_q, frame_d;

  logic          last_cycle;
  logic          enter_lo;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  // Single decoder shared by both digits; it looks at the digit about to be shown.
  bcd u_bcd (
    .i_nibble   (nibble),
    .o_segments (glyph)
  );

  // Next-state: dwell counter, phase sequencing, frame latch and output drive.
  always_comb begin
    last_cycle = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    if ((state_q == SHOW_LO) || (state_q == SHOW_HI)) begin
      last_cycle = (cnt_q == SHOW_LAST);
    end else begin
      last_cycle = !HAS_BLANK || (cnt_q == BLANK_LAST);
    end

    if (last_cycle) begin
      cnt_d = '0;
      case (state_q)
        BLANK_TO_LO: state_d = SHOW_LO;
        SHOW_LO:     state_d = HAS_BLANK ? BLANK_TO_HI : SHOW_HI;
        BLANK_TO_HI: state_d = SHOW_HI;
        default:     state_d = HAS_BLANK ? BLANK_TO_LO : SHOW_LO;
      endcase
    end

    // Sampling only on frame entry keeps the two digits of one frame consistent.
    enter_lo = (state_d == SHOW_LO) && (state_q != SHOW_LO);
    val_d    = enter_lo ? bus.i_value : val_q;
    nibble   = (state_d == SHOW_HI) ? val_d[7:4] : val_d[3:0];

    seg_d  = SEG_OFF;
    cath_d = cath_q;
    case (state_d)
      SHOW_LO: begin
        seg_d  = ~glyph;
        cath_d = DIGIT_LO;
      end
      SHOW_HI: begin
        seg_d  = (SUPPRESS_LEADING_ZERO && (val_d[7:4] == 4'h0)) ? SEG_OFF : ~glyph;
        cath_d = DIGIT_HI;
      end
      default: begin
        seg_d  = SEG_OFF;
        cath_d = cath_q;
      end
    endcase
    // Disable only darkens the bus; sequencing carries on underneath.
    if (!bus.i_enable) begin
      seg_d = SEG_OFF;
    end

    frame_d = enter_lo;
  end

  // Registered FSM state, counter, latched value and PMOD drive.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= BLANK_TO_LO;
      cnt_q   <= '0;
      val_q   <= 8'h00;
      seg_q   <= SEG_OFF;
      cath_q  <= DIGIT_LO;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      seg_q   <= seg_d;
      cath_q  <= cath_d;
      frame_q <= frame_d;
    end
  end

  assign bus.o_segments = seg_q;
  assign bus.o_cathode  = cath_q;
  assign bus.o_frame    = frame_q;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Bench for sev_seg_mux: three configurations driven from shared stimulus.
// A frame-position model predicts every output each cycle; directed literals pin it.
// Random values and enable drops follow a directed timeline.
module tb_sev_seg_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'h3A;
  logic       enable = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sev_seg_mux_if ifa ();
  sev_seg_mux_if ifb ();
  sev_seg_mux_if ifc ();

  assign ifa.i_value = value;  assign ifa.i_enable = enable;
  assign ifb.i_value = value;  assign ifb.i_enable = enable;
  assign ifc.i_value = value;  assign ifc.i_enable = enable;

  sev_seg_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .SUPPRESS_LEADING_ZERO(1'b0)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .bus(ifa));
  sev_seg_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .SUPPRESS_LEADING_ZERO(1'b1)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .bus(ifb));
  sev_seg_mux #(.REFRESH_DIV(3), .BLANK_CYCLES(0), .SUPPRESS_LEADING_ZERO(1'b0)) dut_c (
    .i_clock(clk), .i_reset_n(rst_n), .bus(ifc));

  localparam int RD [3] = '{4, 4, 3};
  localparam int BC [3] = '{2, 2, 0};
  localparam bit SZ [3] = '{1'b0, 1'b1, 1'b0};
  // Active-high glyphs, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: position inside the frame is simply edges-since-reset modulo the period.
  int         t = 0;
  logic [7:0] lat   [3];
  logic [6:0] eseg  [3];
  logic       ecath [3];
  logic       efrm  [3];

  always @(posedge clk or negedge rst_n) begin
    int p, pos;
    if (!rst_n) begin
      t = 0;
      for (int k = 0; k < 3; k++) begin
        lat[k] = 8'h00; eseg[k] = 7'h7F; ecath[k] = 1'b1; efrm[k] = 1'b0;
      end
    end else begin
      t++;
      for (int k = 0; k < 3; k++) begin
        p   = 2 * (RD[k] + BC[k]);
        // Without blanking there is still the single reset cycle before the low digit.
        pos = ((BC[k] == 0) ? (t - 1) : t) % p;
        efrm[k] = (pos == BC[k]);
        if (efrm[k]) lat[k] = value;
        if (pos >= BC[k] && pos < BC[k] + RD[k]) begin
          ecath[k] = 1'b1;
          eseg[k]  = enable ? ~HEX[lat[k][3:0]] : 7'h7F;
        end else if (pos >= 2 * BC[k] + RD[k]) begin
          ecath[k] = 1'b0;
          eseg[k]  = (!enable || (SZ[k] && lat[k][7:4] == 4'h0)) ? 7'h7F : ~HEX[lat[k][7:4]];
        end else begin
          eseg[k] = 7'h7F;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of every DUT against the model.
  always @(negedge clk) begin
    chk("a_seg",   ifa.o_segments, eseg[0]);
    chk("a_cath",  ifa.o_cathode,  ecath[0]);
    chk("a_frame", ifa.o_frame,    efrm[0]);
    chk("b_seg",   ifb.o_segments, eseg[1]);
    chk("b_cath",  ifb.o_cathode,  ecath[1]);
    chk("b_frame", ifb.o_frame,    efrm[1]);
    chk("c_seg",   ifc.o_segments, eseg[2]);
    chk("c_cath",  ifc.o_cathode,  ecath[2]);
    chk("c_frame", ifc.o_frame,    efrm[2]);
  end

  int e = 0;

  task automatic step();
    @(negedge clk);
    e++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a_seg",   ifa.o_segments, 7'h7F);
    chk("rst_a_cath",  ifa.o_cathode,  1'b1);
    chk("rst_a_frame", ifa.o_frame,    1'b0);
    chk("rst_c_seg",   ifc.o_segments, 7'h7F);
    rst_n = 1'b1;
    e = 0;

    while (e < 69) begin
      step();
      case (e)
        1:  begin chk("blank0_seg", ifa.o_segments, 7'h7F); chk("blank0_cath", ifa.o_cathode, 1'b1);
                  chk("c_first_lo", ifc.o_segments, 7'h08); chk("c_first_frm", ifc.o_frame, 1'b1); end
        2:  begin chk("lo_seg_A", ifa.o_segments, 7'h08); chk("lo_cath", ifa.o_cathode, 1'b1);
                  chk("frame_first", ifa.o_frame, 1'b1); end
        3:  chk("frame_once", ifa.o_frame, 1'b0);
        4:  begin chk("c_hi_seg_3", ifc.o_segments, 7'h30); chk("c_hi_cath", ifc.o_cathode, 1'b0); end
        6:  begin chk("blank_hi_seg", ifa.o_segments, 7'h7F); chk("blank_hi_cath", ifa.o_cathode, 1'b1); end
        8:  begin chk("hi_seg_3", ifa.o_segments, 7'h30); chk("hi_cath", ifa.o_cathode, 1'b0); end
        12: begin chk("blank_lo_seg", ifa.o_segments, 7'h7F); chk("blank_lo_cath", ifa.o_cathode, 1'b0); end
        14: chk("frame_period12", ifa.o_frame, 1'b1);
        15: value = 8'hC5;
        22: chk("no_tear_hi_3", ifa.o_segments, 7'h30);
        26: begin chk("next_lo_5", ifa.o_segments, 7'h12); chk("next_frame", ifa.o_frame, 1'b1); end
        27: value = 8'h07;
        32: chk("next_hi_C", ifa.o_segments, 7'h46);
        38: begin chk("lz_lo_7", ifb.o_segments, 7'h78); chk("lz_lo_cath", ifb.o_cathode, 1'b1); end
        44: begin chk("lz_hi_dark", ifb.o_segments, 7'h7F); chk("lz_hi_cath", ifb.o_cathode, 1'b0);
                  chk("nolz_hi_0", ifa.o_segments, 7'h40); end
        45: value = 8'hFF;
        49: begin chk("nb_lo_F", ifc.o_segments, 7'h0E); chk("nb_lo_cath", ifc.o_cathode, 1'b1);
                  chk("nb_frame", ifc.o_frame, 1'b1); end
        52: begin chk("nb_hi_F", ifc.o_segments, 7'h0E); chk("nb_hi_cath", ifc.o_cathode, 1'b0);
                  chk("nb_nofrm", ifc.o_frame, 1'b0); end
        55: chk("nb_period6", ifc.o_frame, 1'b1);
        56: begin chk("en_hi_lit", ifa.o_segments, 7'h0E); enable = 1'b0; end
        57: begin chk("en_off_seg", ifa.o_segments, 7'h7F); chk("en_off_cath", ifa.o_cathode, 1'b0); end
        61: enable = 1'b1;
        62: begin chk("en_frame_kept", ifa.o_frame, 1'b1); chk("en_back_lo", ifa.o_segments, 7'h0E);
                  chk("en_back_cath", ifa.o_cathode, 1'b1); end
        69: chk("pre_rst_hi", ifa.o_segments, 7'h0E);
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of SHOW_HI, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg",   ifa.o_segments, 7'h7F);
    chk("arst_cath",  ifa.o_cathode,  1'b1);
    chk("arst_frame", ifa.o_frame,    1'b0);
    chk("arst_c_seg", ifc.o_segments, 7'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    step();
    chk("post_rst_dark", ifa.o_segments, 7'h7F);
    step();
    chk("post_rst_lo", ifa.o_segments, 7'h0E);
    chk("post_rst_cath", ifa.o_cathode, 1'b1);

    // Random phase checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      value = 8'($urandom);
      if ($urandom_range(0, 3) == 0) value[7:4] = 4'h0;
      enable = ($urandom_range(0, 7) != 0);
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
